// File: rtl/wishbone_arbiter.sv
// Two-master, one-slave Wishbone B4 classic arbiter: fair round-robin grant held for a
// whole transaction, with a watchdog that aborts unacknowledged slave cycles and reports ERR.
module wishbone_arbiter #(
    parameter int ADDR_SIZE      = 32,
    parameter int DATA_SIZE      = 32,
    parameter int BYTE_AMNT      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,

    input  logic                 m0_CYC_I,
    input  logic                 m0_STB_I,
    input  logic                 m0_WE_I,
    input  logic [BYTE_AMNT-1:0] m0_SEL_I,
    input  logic [ADDR_SIZE-1:0] m0_ADR_I,
    input  logic [DATA_SIZE-1:0] m0_DAT_I,
    output logic [DATA_SIZE-1:0] m0_DAT_O,
    output logic                 m0_ACK_O,
    output logic                 m0_ERR_O,

    input  logic                 m1_CYC_I,
    input  logic                 m1_STB_I,
    input  logic                 m1_WE_I,
    input  logic [BYTE_AMNT-1:0] m1_SEL_I,
    input  logic [ADDR_SIZE-1:0] m1_ADR_I,
    input  logic [DATA_SIZE-1:0] m1_DAT_I,
    output logic [DATA_SIZE-1:0] m1_DAT_O,
    output logic                 m1_ACK_O,
    output logic                 m1_ERR_O,

    output logic                 s_CYC_O,
    output logic                 s_STB_O,
    output logic                 s_WE_O,
    output logic [BYTE_AMNT-1:0] s_SEL_O,
    output logic [ADDR_SIZE-1:0] s_ADR_O,
    output logic [DATA_SIZE-1:0] s_DAT_O,
    input  logic [DATA_SIZE-1:0] s_DAT_I,
    input  logic                 s_ACK_I
);

    localparam int                WDOG_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t            state, state_next;
    logic              last, last_next;
    logic [WDOG_W-1:0] wdog, wdog_next;

    logic req_0, req_1;
    logic granted, owner, own_cyc, own_stb;
    logic wdog_expired, timeout, txn_end;

    assign req_0 = m0_CYC_I & m0_STB_I;
    assign req_1 = m1_CYC_I & m1_STB_I;

    assign granted      = (state != IDLE);
    assign owner        = (state == GNT1);
    assign own_cyc      = owner ? m1_CYC_I : m0_CYC_I;
    assign own_stb      = owner ? m1_STB_I : m0_STB_I;
    assign wdog_expired = (wdog == WDOG_LAST);

    // ACK on the final watchdog cycle completes the transfer normally instead of erroring.
    assign timeout = granted & wdog_expired & ~s_ACK_I & own_cyc;
    assign txn_end = granted & (s_ACK_I | ~own_cyc | wdog_expired);

    // Read data is broadcast; only the owning master sees ACK, so the others ignore it.
    assign m0_DAT_O = s_DAT_I;
    assign m1_DAT_O = s_DAT_I;
    assign m0_ACK_O = (state == GNT0) & s_ACK_I;
    assign m1_ACK_O = (state == GNT1) & s_ACK_I;
    assign m0_ERR_O = (state == GNT0) & timeout;
    assign m1_ERR_O = (state == GNT1) & timeout;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path leaves a latch.
        s_CYC_O = 1'b0;
        s_STB_O = 1'b0;
        s_WE_O  = 1'b0;
        s_SEL_O = '0;
        s_ADR_O = '0;
        s_DAT_O = '0;
        if (granted) begin
            s_CYC_O = own_cyc & ~timeout;
            s_STB_O = own_stb & ~timeout;
            s_WE_O  = owner ? m1_WE_I  : m0_WE_I;
            s_SEL_O = owner ? m1_SEL_I : m0_SEL_I;
            s_ADR_O = owner ? m1_ADR_I : m0_ADR_I;
            s_DAT_O = owner ? m1_DAT_I : m0_DAT_I;
        end
    end

    always_comb begin
        state_next = state;
        last_next  = last;
        wdog_next  = '0;
        case (state)
            IDLE: begin
                if (req_0 && req_1) state_next = last ? GNT0 : GNT1;
                else if (req_0)     state_next = GNT0;
                else if (req_1)     state_next = GNT1;
            end
            GNT0, GNT1: begin
                if (txn_end) begin
                    state_next = IDLE;
                    last_next  = owner;
                end else begin
                    wdog_next = wdog + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        // NOTE: state registers use non-blocking assignments so all of them update together.
        if (!RST_I) begin
            state <= IDLE;
            last  <= 1'b1;
            wdog  <= '0;
        end else begin
            state <= state_next;
            last  <= last_next;
            wdog  <= wdog_next;
        end
    end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Self-checking bench for wishbone_arbiter: directed scenarios with literal expectations,
// then randomized masters and slave checked every cycle against a transaction-level model.
module tb_wishbone_arbiter;

    localparam int TIMEOUT = 16;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b0;
    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic [3:0]  m_sel [2];
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [31:0] dat_o0, dat_o1;
    logic        ack0, ack1, err0, err1;
    logic        s_CYC_O, s_STB_O, s_WE_O;
    logic [3:0]  s_SEL_O;
    logic [31:0] s_ADR_O, s_DAT_O;
    logic [31:0] s_dat;
    logic        s_ack;

    int checks = 0;
    int errors = 0;

    always #5 CLK_I = ~CLK_I;

    wishbone_arbiter #(.ADDR_SIZE(32), .DATA_SIZE(32), .BYTE_AMNT(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .m0_CYC_I(m_cyc[0]), .m0_STB_I(m_stb[0]), .m0_WE_I(m_we[0]), .m0_SEL_I(m_sel[0]),
        .m0_ADR_I(m_adr[0]), .m0_DAT_I(m_dat[0]), .m0_DAT_O(dat_o0), .m0_ACK_O(ack0), .m0_ERR_O(err0),
        .m1_CYC_I(m_cyc[1]), .m1_STB_I(m_stb[1]), .m1_WE_I(m_we[1]), .m1_SEL_I(m_sel[1]),
        .m1_ADR_I(m_adr[1]), .m1_DAT_I(m_dat[1]), .m1_DAT_O(dat_o1), .m1_ACK_O(ack1), .m1_ERR_O(err1),
        .s_CYC_O(s_CYC_O), .s_STB_O(s_STB_O), .s_WE_O(s_WE_O), .s_SEL_O(s_SEL_O),
        .s_ADR_O(s_ADR_O), .s_DAT_O(s_DAT_O), .s_DAT_I(s_dat), .s_ACK_I(s_ack)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: owner is -1 when nobody holds the bus; gnum counts the granted
    // cycles of the current transaction starting at 1, so the TIMEOUT-th one is the last.
    int         owner = -1;
    int         last  = 1;
    int         gnum  = 0;
    logic [1:0] ended = 2'b00;

    function automatic bit req(input int x);
        return m_cyc[x] && m_stb[x];
    endfunction

    always @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            owner <= -1;
            last  <= 1;
            gnum  <= 0;
            ended <= 2'b00;
        end else begin
            ended <= 2'b00;
            if (owner < 0) begin
                if (req(0) && req(1)) owner <= 1 - last;
                else if (req(0))      owner <= 0;
                else if (req(1))      owner <= 1;
                gnum <= 1;
            end else if (s_ack || !m_cyc[owner] || gnum == TIMEOUT) begin
                if (s_ack || m_cyc[owner]) ended[owner] <= 1'b1;
                last  <= owner;
                owner <= -1;
            end else begin
                gnum <= gnum + 1;
            end
        end
    end

    // Compare process: outputs are combinational in the inputs, which settle 1ns after posedge.
    always @(negedge CLK_I) begin
        bit         gr, tmo;
        logic       e_we;
        logic [3:0] e_sel;
        logic [31:0] e_adr, e_dat;
        gr    = (owner >= 0);
        tmo   = gr && gnum == TIMEOUT && !s_ack && m_cyc[owner];
        e_we  = gr ? m_we[owner]  : 1'b0;
        e_sel = gr ? m_sel[owner] : 4'h0;
        e_adr = gr ? m_adr[owner] : 32'h0;
        e_dat = gr ? m_dat[owner] : 32'h0;
        check("s_cyc", s_CYC_O, gr && m_cyc[owner] && !tmo);
        check("s_stb", s_STB_O, gr && m_stb[owner] && !tmo);
        check("s_we",  s_WE_O,  e_we);
        check("s_sel", s_SEL_O, e_sel);
        check("s_adr", s_ADR_O, e_adr);
        check("s_dat", s_DAT_O, e_dat);
        check("m0_ack", ack0, owner == 0 && s_ack);
        check("m1_ack", ack1, owner == 1 && s_ack);
        check("m0_err", err0, owner == 0 && tmo);
        check("m1_err", err1, owner == 1 && tmo);
        check("m0_dat_o", dat_o0, s_dat);
        check("m1_dat_o", dat_o1, s_dat);
    end

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK_I);
        #1;
    endtask

    task automatic set_req(input int x, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        m_cyc[x] = 1'b1;
        m_stb[x] = 1'b1;
        m_we[x]  = we;
        m_sel[x] = 4'hF;
        m_adr[x] = adr;
        m_dat[x] = dat;
    endtask

    task automatic drop_req(input int x);
        m_cyc[x] = 1'b0;
        m_stb[x] = 1'b0;
    endtask

    int       err_at;
    int       ack_pct;
    int       gq[$];
    bit [1:0] active;

    initial begin
        for (int x = 0; x < 2; x++) begin
            drop_req(x);
            m_we[x] = 1'b0; m_sel[x] = 4'h0; m_adr[x] = 32'h0; m_dat[x] = 32'h0;
        end
        s_ack = 1'b0;
        s_dat = 32'h0;

        // Reset state.
        mid();
        check("rst_s_cyc", s_CYC_O, 1'b0);
        check("rst_ack", {ack0, ack1, err0, err1}, 4'b0000);
        tick();
        RST_I = 1'b1;

        // Both masters request together out of reset: m0 first, m1 after one idle cycle.
        tick();
        set_req(0, 1'b0, 32'h0000_0100, 32'h0);
        set_req(1, 1'b1, 32'h0100_0000, 32'hCAFE_F00D);
        mid();
        check("tie_arb_idle", s_CYC_O, 1'b0);
        tick();
        s_ack = 1'b1;
        mid();
        check("tie_m0_first_adr", s_ADR_O, 32'h0000_0100);
        check("tie_m0_ack", ack0, 1'b1);
        check("tie_m1_no_ack", ack1, 1'b0);
        tick();
        drop_req(0);
        s_ack = 1'b0;
        mid();
        check("tie_gap_idle", s_CYC_O, 1'b0);
        tick();
        s_ack = 1'b1;
        mid();
        check("tie_m1_adr", s_ADR_O, 32'h0100_0000);
        check("tie_m1_we", s_WE_O, 1'b1);
        check("tie_m1_ack", ack1, 1'b1);
        tick();
        drop_req(1);
        s_ack = 1'b0;

        // Single m0 read of ROM word 0.
        tick();
        set_req(0, 1'b0, 32'h0, 32'h0);
        mid();
        check("rd_arb_cycle", s_CYC_O, 1'b0);
        tick();
        s_ack = 1'b1;
        s_dat = 32'h0000_0013;
        mid();
        check("rd_s_cyc", s_CYC_O, 1'b1);
        check("rd_m0_dat", dat_o0, 32'h0000_0013);
        check("rd_m1_ack", ack1, 1'b0);
        tick();
        drop_req(0);
        s_ack = 1'b0;

        // Watchdog: m1 alone, slave never acks.
        tick();
        set_req(1, 1'b0, 32'h0100_0040, 32'h0);
        err_at = -1;
        for (int i = 0; i < 40; i++) begin
            mid();
            if (err1 === 1'b1) begin
                err_at = i;
                break;
            end
            tick();
        end
        check("tmo_latency", err_at, TIMEOUT);
        check("tmo_s_cyc_low", s_CYC_O, 1'b0);
        check("tmo_no_m0_err", err0, 1'b0);
        tick();
        mid();
        check("tmo_back_idle", s_CYC_O, 1'b0);
        check("tmo_err_single", err1, 1'b0);
        drop_req(1);

        // ACK on the watchdog's final cycle wins over ERR.
        tick();
        set_req(0, 1'b0, 32'h0000_0008, 32'h0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            if (i == TIMEOUT) s_ack = 1'b1;
            mid();
        end
        check("tmo_ack_ack", ack0, 1'b1);
        check("tmo_ack_err", err0, 1'b0);
        check("tmo_ack_cyc", s_CYC_O, 1'b1);
        tick();
        s_ack = 1'b0;
        drop_req(0);

        // m0 abandons its cycle while m1 waits.
        tick();
        set_req(0, 1'b0, 32'h0000_0020, 32'h0);
        mid();
        tick();
        set_req(1, 1'b1, 32'h0100_0000, 32'h1234_5678);
        mid();
        check("abort_m0_granted", s_ADR_O, 32'h0000_0020);
        tick();
        drop_req(0);
        mid();
        check("abort_same_cycle", s_CYC_O, 1'b0);
        tick();
        mid();
        check("abort_idle_gap", s_CYC_O, 1'b0);
        tick();
        mid();
        check("abort_m1_grant", s_CYC_O, 1'b1);
        check("abort_m1_adr", s_ADR_O, 32'h0100_0000);

        // Asynchronous reset in the middle of the m1 RAM write.
        RST_I = 1'b0;
        #1;
        check("rst_mid_s_cyc", s_CYC_O, 1'b0);
        check("rst_mid_ack_err", {ack1, err1}, 2'b00);
        tick();
        tick();
        RST_I = 1'b1;
        set_req(0, 1'b0, 32'h0000_0030, 32'h0);
        mid();

        // Both masters keep requesting: grants alternate starting with m0.
        s_ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            mid();
            if (ack0) gq.push_back(0);
            if (ack1) gq.push_back(1);
        end
        check("alt_count", gq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < gq.size()) check($sformatf("alt_grant_%0d", i), gq[i], i % 2);
        end
        tick();
        drop_req(0);
        drop_req(1);
        s_ack = 1'b0;

        // Randomized traffic, alternating responsive and stalling slave phases.
        active = 2'b00;
        for (int c = 0; c < 4000; c++) begin
            tick();
            ack_pct = ((c / 400) % 2 == 0) ? 45 : 3;
            for (int x = 0; x < 2; x++) begin
                if (active[x]) begin
                    if (ended[x]) begin
                        drop_req(x);
                        active[x] = 1'b0;
                    end else if ($urandom_range(0, 59) == 0) begin
                        drop_req(x);
                        active[x] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    set_req(x, 1'($urandom_range(0, 1)), $urandom, $urandom);
                    m_sel[x]  = 4'($urandom);
                    active[x] = 1'b1;
                end
            end
            s_ack = ($urandom_range(0, 99) < ack_pct);
            s_dat = $urandom;
            if (c == 2500) begin
                RST_I = 1'b0;
                #2;
                RST_I = 1'b1;
            end
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
